// File: rtl/ex_defs_pkg.sv
// Shared definitions for the execute stage: RV32I opcode/funct constants,
// the canonical NOP, the divider FSM state encoding and immediate decoders.
package ex_defs_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for the M-extension divides (bit2 set marks a divide)
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Divider sequencing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// start is sampled in IDLE; busy covers the 32 shift/subtract steps; done is
// a one-cycle pulse carrying the signed-corrected result plus the latched
// destination register and PC. Divide-by-zero and signed overflow skip BUSY.
module ex_div
    import ex_defs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,        // funct3[1:0]: bit0 = unsigned, bit1 = remainder
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_pc
);

    div_state_t r_state;
    div_state_t w_state_next;

    logic [XLEN-1:0] r_quot;     // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [4:0]      r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_pc;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quot_step;

    assign w_signed   = ~i_op[0];
    assign w_a_neg    = w_signed & i_dividend[XLEN-1];
    assign w_b_neg    = w_signed & i_divisor[XLEN-1];
    assign w_a_mag    = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag    = w_b_neg ? -i_divisor  : i_divisor;
    assign w_div_zero = (i_divisor == '0);
    assign w_overflow = w_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                                 && (i_divisor == '1);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    assign w_shift     = {r_rem, r_quot[XLEN-1]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_rem_step  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quot_step = {r_quot[XLEN-2:0], ~w_diff[XLEN]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state: special cases jump straight to DONE, otherwise 32 BUSY steps
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_state_next = (w_div_zero || w_overflow) ? DONE : BUSY;
            BUSY: if (r_cnt == 5'd31) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch on start, iterate while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_rd_addr <= '0;
            r_pc      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_is_rem  <= i_op[1];
                        r_rd_addr <= i_rd_addr;
                        r_pc      <= i_pc;
                        r_cnt     <= '0;
                        r_divisor <= w_b_mag;
                        if (w_div_zero) begin
                            r_quot  <= '1;
                            r_rem   <= i_dividend;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_overflow) begin
                            r_quot  <= {1'b1, {(XLEN-1){1'b0}}};
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quot  <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                BUSY: begin
                    r_quot <= w_quot_step;
                    r_rem  <= w_rem_step;
                    r_cnt  <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == BUSY);
    assign o_done    = (r_state == DONE);
    assign o_result  = r_is_rem ? (r_neg_r ? -r_rem  : r_rem)
                                : (r_neg_q ? -r_quot : r_quot);
    assign o_rd_addr = r_rd_addr;
    assign o_pc      = r_pc;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage. ALU, branches and jumps resolve in the cycle they are
// presented. Optional divider enabled by the macro EX_DIV_EN: a divide holds
// the front end until the result is written back, then redirects to PC+4 to
// refetch the successor that was flushed while the divide was in flight.
// Without EX_DIV_EN divide encodings behave as NOPs and hold_req_o is 0.
module ex_stage
    import ex_defs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic            jump_en_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            hold_req_o
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_pc_plus4;
    logic [4:0]      w_shamt_r;
    logic [4:0]      w_shamt_i;

    logic            w_alu_valid;
    logic [XLEN-1:0] w_alu_result;
    logic            w_jump;
    logic [XLEN-1:0] w_jump_target;

    logic            w_div_busy;
    logic            w_div_done;
    logic            w_div_start;
    logic [XLEN-1:0] w_div_result;
    logic [4:0]      w_div_rd;
    logic [XLEN-1:0] w_div_pc;

    assign w_opcode   = inst_i[6:0];
    assign w_f3       = inst_i[14:12];
    assign w_f7       = inst_i[31:25];
    assign w_imm_i    = imm_i(inst_i);
    assign w_imm_b    = imm_b(inst_i);
    assign w_imm_u    = imm_u(inst_i);
    assign w_imm_j    = imm_j(inst_i);
    assign w_pc_plus4 = inst_addr_i + 32'd4;
    assign w_shamt_r  = rs2_data_i[4:0];
    assign w_shamt_i  = inst_i[24:20];

`ifdef EX_DIV_EN
    logic w_is_div;

    assign w_is_div    = (w_opcode == OPC_OP) && (w_f7 == F7_MULDIV) && w_f3[2];
    // The divider only accepts a request while idle; in DONE the inputs are a flushed NOP.
    assign w_div_start = w_is_div && !w_div_busy && !w_div_done;

    ex_div #(.XLEN(XLEN)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_op       (w_f3[1:0]),
        .i_dividend (rs1_data_i),
        .i_divisor  (rs2_data_i),
        .i_rd_addr  (rd_addr_i),
        .i_pc       (inst_addr_i),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_result   (w_div_result),
        .o_rd_addr  (w_div_rd),
        .o_pc       (w_div_pc)
    );
`else
    assign w_div_start  = 1'b0;
    assign w_div_busy   = 1'b0;
    assign w_div_done   = 1'b0;
    assign w_div_result = '0;
    assign w_div_rd     = '0;
    assign w_div_pc     = '0;
`endif

    // Single-cycle decode/execute of everything except divides
    always_comb begin
        w_alu_valid   = 1'b0;
        w_alu_result  = '0;
        w_jump        = 1'b0;
        w_jump_target = '0;
        case (w_opcode)
            OPC_LUI: begin
                w_alu_valid  = 1'b1;
                w_alu_result = w_imm_u;
            end
            OPC_AUIPC: begin
                w_alu_valid  = 1'b1;
                w_alu_result = inst_addr_i + w_imm_u;
            end
            OPC_JAL: begin
                w_alu_valid   = 1'b1;
                w_alu_result  = w_pc_plus4;
                w_jump        = 1'b1;
                w_jump_target = inst_addr_i + w_imm_j;
            end
            OPC_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_alu_valid   = 1'b1;
                    w_alu_result  = w_pc_plus4;
                    w_jump        = 1'b1;
                    w_jump_target = (rs1_data_i + w_imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                w_jump_target = inst_addr_i + w_imm_b;
                case (w_f3)
                    F3_BEQ:  w_jump = (rs1_data_i == rs2_data_i);
                    F3_BNE:  w_jump = (rs1_data_i != rs2_data_i);
                    F3_BLT:  w_jump = ($signed(rs1_data_i) <  $signed(rs2_data_i));
                    F3_BGE:  w_jump = ($signed(rs1_data_i) >= $signed(rs2_data_i));
                    F3_BLTU: w_jump = (rs1_data_i <  rs2_data_i);
                    F3_BGEU: w_jump = (rs1_data_i >= rs2_data_i);
                    default: w_jump = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_alu_valid = 1'b1;
                case (w_f3)
                    F3_ADD:  w_alu_result = rs1_data_i + w_imm_i;
                    F3_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(w_imm_i)};
                    F3_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, rs1_data_i < w_imm_i};
                    F3_XOR:  w_alu_result = rs1_data_i ^ w_imm_i;
                    F3_OR:   w_alu_result = rs1_data_i | w_imm_i;
                    F3_AND:  w_alu_result = rs1_data_i & w_imm_i;
                    F3_SLL: begin
                        w_alu_valid  = (w_f7 == F7_BASE);
                        w_alu_result = rs1_data_i << w_shamt_i;
                    end
                    F3_SR: begin
                        if (w_f7 == F7_BASE)
                            w_alu_result = rs1_data_i >> w_shamt_i;
                        else if (w_f7 == F7_ALT)
                            w_alu_result = $signed(rs1_data_i) >>> w_shamt_i;
                        else
                            w_alu_valid = 1'b0;
                    end
                    default: w_alu_valid = 1'b0;
                endcase
            end
            OPC_OP: begin
                if (w_f7 == F7_BASE) begin
                    w_alu_valid = 1'b1;
                    case (w_f3)
                        F3_ADD:  w_alu_result = rs1_data_i + rs2_data_i;
                        F3_SLL:  w_alu_result = rs1_data_i << w_shamt_r;
                        F3_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(rs2_data_i)};
                        F3_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, rs1_data_i < rs2_data_i};
                        F3_XOR:  w_alu_result = rs1_data_i ^ rs2_data_i;
                        F3_SR:   w_alu_result = rs1_data_i >> w_shamt_r;
                        F3_OR:   w_alu_result = rs1_data_i | rs2_data_i;
                        F3_AND:  w_alu_result = rs1_data_i & rs2_data_i;
                        default: w_alu_valid  = 1'b0;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == F3_ADD) begin
                        w_alu_valid  = 1'b1;
                        w_alu_result = rs1_data_i - rs2_data_i;
                    end else if (w_f3 == F3_SR) begin
                        w_alu_valid  = 1'b1;
                        w_alu_result = $signed(rs1_data_i) >>> w_shamt_r;
                    end
                end
                // F7_MULDIV falls through as a NOP here; divides go to the divider.
            end
            default: ;
        endcase
    end

    // Output select: reset forces zeros, divider writeback and stalls take
    // priority over the instruction currently at the inputs.
    always_comb begin
        rd_addr_o   = '0;
        rd_data_o   = '0;
        rd_wen_o    = 1'b0;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        hold_req_o  = 1'b0;
        if (!rst_n) begin
            // all outputs stay at zero
        end else if (w_div_done) begin
            rd_addr_o   = w_div_rd;
            rd_data_o   = w_div_result;
            rd_wen_o    = 1'b1;
            jump_en_o   = 1'b1;
            jump_addr_o = w_div_pc + 32'd4;
        end else if (w_div_busy || w_div_start) begin
            hold_req_o  = 1'b1;
        end else begin
            rd_addr_o   = rd_addr_i;
            rd_data_o   = w_alu_result;
            rd_wen_o    = rd_wen_i && w_alu_valid;
            jump_en_o   = w_jump;
            jump_addr_o = w_jump_target;
        end
    end

endmodule
